simt_reconv_unit: RTL

//  Shared per-core PC and divergence/reconvergence controller for SIMT execution. Tracks the active

---
 rtl/simt_pkg.sv | 33 +++
 rtl/simt_stack_mem.sv | 62 ++++++
 rtl/simt_reconv_unit.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/simt_pkg.sv
// Shared definitions for the SIMT reconvergence controller: scheduler state
// encoding, reconvergence stack entry kinds, the default-geometry stack entry
// layout and a small NZP condition helper.
package simt_pkg;

    // Scheduler state in which the controller commits PC / mask updates.
    localparam logic [3:0] CORE_UPDATE = 4'd6;

    // Default block geometry.
    localparam int SIMT_TPB         = 4;
    localparam int SIMT_STACK_DEPTH = 4;
    localparam int SIMT_PC_BITS     = 8;

    // RECONV entries come from SSY (join point), DIV entries from a split branch.
    typedef enum logic [0:0] {
        KIND_RECONV = 1'b0,
        KIND_DIV    = 1'b1
    } entry_kind_e;

    // Stack entry layout at the default geometry; the top module declares the
    // same layout sized by its own parameters.
    typedef struct packed {
        entry_kind_e               kind;
        logic [SIMT_PC_BITS-1:0]   pc;
        logic [SIMT_TPB-1:0]       mask;
    } stack_entry_t;

    // A lane takes a conditional branch when any of its NZP flags matches.
    function automatic logic nzp_match(input logic [2:0] flags, input logic [2:0] cond);
        return |(flags & cond);
    endfunction

endpackage

// File: rtl/simt_stack_mem.sv
// LIFO storage for reconvergence entries. Push into a full stack and pop from
// an empty stack are ignored here; the controller flags those conditions.
module simt_stack_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 13
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         i_clr,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [WIDTH-1:0]             i_data,
    output logic [WIDTH-1:0]             o_top,
    output logic [$clog2(DEPTH+1)-1:0]   o_depth,
    output logic                         o_full,
    output logic                         o_empty
);
    localparam int DW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DW-1:0]    r_count;
    logic [DW-1:0]    w_top_idx;

    assign o_depth   = r_count;
    assign o_full    = (r_count == DW'(DEPTH));
    assign o_empty   = (r_count == {DW{1'b0}});
    assign w_top_idx = r_count - DW'(1);

    // Select the most recently pushed entry (zero when empty).
    always_comb begin
        o_top = {WIDTH{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            o_top = o_top | ({WIDTH{(!o_empty) && (w_top_idx == DW'(k))}} & r_mem[k]);
        end
    end

    // Entry storage and occupancy counter; clear empties the stack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= {DW{1'b0}};
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= {WIDTH{1'b0}};
            end
        end else if (i_clr) begin
            r_count <= {DW{1'b0}};
        end else if (i_push && !o_full) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (r_count == DW'(k)) begin
                    r_mem[k] <= i_data;
                end else begin
                    r_mem[k] <= r_mem[k];
                end
            end
            r_count <= r_count + DW'(1);
        end else if (i_pop && !o_empty) begin
            r_count <= r_count - DW'(1);
        end else begin
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/simt_reconv_unit.sv
// Shared PC and divergence/reconvergence controller for a SIMT core.
// Optional build macro SIMT_DIV_STATS_EN enables the divergence counter and
// stack high-water mark; without it those outputs are tied to zero.
module simt_reconv_unit
    import simt_pkg::*;
#(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int STACK_DEPTH       = 4,
    parameter int PC_BITS           = 8
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  start,
    input  logic [$clog2(THREADS_PER_BLOCK):0]    thread_count,
    input  logic [3:0]                            core_state,
    input  logic                                  decoded_pc_mux,
    input  logic                                  decoded_jump,
    input  logic                                  decoded_ssy,
    input  logic                                  decoded_sync,
    input  logic                                  decoded_ret,
    input  logic [2:0]                            decoded_nzp,
    input  logic [PC_BITS-1:0]                    decoded_immediate,
    input  logic [3*THREADS_PER_BLOCK-1:0]        nzp,
    output logic [PC_BITS-1:0]                    current_pc,
    output logic [THREADS_PER_BLOCK-1:0]          thread_mask,
    output logic [$clog2(STACK_DEPTH+1)-1:0]      stack_depth,
    output logic                                  all_retired,
    output logic                                  stack_overflow,
    output logic                                  stack_underflow,
    output logic [15:0]                           div_count,
    output logic [$clog2(STACK_DEPTH+1)-1:0]      max_depth
);
    localparam int TPB = THREADS_PER_BLOCK;
    localparam int DW  = $clog2(STACK_DEPTH+1);
    localparam int TCW = $clog2(TPB) + 1;

    typedef struct packed {
        entry_kind_e          kind;
        logic [PC_BITS-1:0]   pc;
        logic [TPB-1:0]       mask;
    } entry_t;
    localparam int EW = $bits(entry_t);

    logic [PC_BITS-1:0] r_pc, w_pc_nxt, w_pc_inc;
    logic [TPB-1:0]     r_mask, w_mask_nxt, r_retired, w_retired_nxt;
    logic [TPB-1:0]     w_launch, w_taken;
    logic               r_all_retired, w_all_nxt, r_ovf, r_unf;
    logic               w_in_update, w_push_req, w_push, w_pop, w_ovf_set, w_unf_set;
    logic               w_full, w_empty;
    entry_t             w_push_entry, w_top;

    assign current_pc      = r_pc;
    assign thread_mask     = r_mask;
    assign all_retired     = r_all_retired;
    assign stack_overflow  = r_ovf;
    assign stack_underflow = r_unf;

    assign w_in_update = (core_state == CORE_UPDATE) && !start;
    assign w_pc_inc    = r_pc + PC_BITS'(1);
    assign w_push      = w_push_req & ~w_full;
    assign w_ovf_set   = w_push_req & w_full;

    simt_stack_mem #(.DEPTH(STACK_DEPTH), .WIDTH(EW)) u_stack (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (start),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_push_entry),
        .o_top   (w_top),
        .o_depth (stack_depth),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Launch mask (lanes below thread_count, capped at TPB) and per-lane branch outcome.
    always_comb begin
        w_launch = '0;
        w_taken  = '0;
        for (int i = 0; i < TPB; i++) begin
            w_launch[i] = (TCW'(i) < thread_count);
            w_taken[i]  = r_mask[i] & nzp_match(nzp[3*i +: 3], decoded_nzp);
        end
    end

    // Next PC / mask / retirement and stack request for the current UPDATE step.
    always_comb begin
        w_pc_nxt      = r_pc;
        w_mask_nxt    = r_mask;
        w_retired_nxt = r_retired;
        w_all_nxt     = r_all_retired;
        w_push_req    = 1'b0;
        w_pop         = 1'b0;
        w_unf_set     = 1'b0;
        w_push_entry  = '{kind: KIND_RECONV, pc: decoded_immediate, mask: r_mask};
        if (!w_in_update) begin
            w_pc_nxt = r_pc;
        end else if (r_mask == '0) begin
            // No live lane: unwind one level as a SYNC would, or finish the block.
            if (!w_empty) begin
                w_pop      = 1'b1;
                w_mask_nxt = w_top.mask & ~r_retired;
                w_pc_nxt   = (w_top.kind == KIND_DIV) ? w_top.pc : w_pc_inc;
            end else begin
                w_all_nxt = r_all_retired | (&r_retired);
            end
        end else if (decoded_ret) begin
            w_retired_nxt = r_retired | r_mask;
            if (!w_empty) begin
                w_pop      = 1'b1;
                w_mask_nxt = w_top.mask & ~w_retired_nxt;
                w_pc_nxt   = w_top.pc;
            end else begin
                w_mask_nxt = '0;
                w_all_nxt  = r_all_retired | (&w_retired_nxt);
            end
        end else if (decoded_sync) begin
            if (!w_empty) begin
                w_pop      = 1'b1;
                w_mask_nxt = w_top.mask & ~r_retired;
                w_pc_nxt   = (w_top.kind == KIND_DIV) ? w_top.pc : w_pc_inc;
            end else begin
                w_pc_nxt  = w_pc_inc;
                w_unf_set = 1'b1;
            end
        end else if (decoded_ssy) begin
            w_push_req = 1'b1;
            w_pc_nxt   = w_pc_inc;
        end else if (decoded_jump) begin
            w_pc_nxt = decoded_immediate;
        end else if (decoded_pc_mux) begin
            if (w_taken == r_mask) begin
                w_pc_nxt = decoded_immediate;
            end else if (w_taken == '0) begin
                w_pc_nxt = w_pc_inc;
            end else begin
                // Split: run the taken lanes first, park the rest at the fall-through.
                w_push_req   = 1'b1;
                w_push_entry = '{kind: KIND_DIV, pc: w_pc_inc, mask: r_mask & ~w_taken};
                w_mask_nxt   = w_taken;
                w_pc_nxt     = decoded_immediate;
            end
        end else begin
            w_pc_nxt = w_pc_inc;
        end
    end

    // Architectural state: launch on start, otherwise commit the computed step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc          <= '0;
            r_mask        <= '0;
            r_retired     <= '0;
            r_all_retired <= 1'b0;
            r_ovf         <= 1'b0;
            r_unf         <= 1'b0;
        end else if (start) begin
            r_pc          <= '0;
            r_mask        <= w_launch;
            r_retired     <= ~w_launch;
            r_all_retired <= 1'b0;
            r_ovf         <= 1'b0;
            r_unf         <= 1'b0;
        end else begin
            r_pc          <= w_pc_nxt;
            r_mask        <= w_mask_nxt;
            r_retired     <= w_retired_nxt;
            r_all_retired <= w_all_nxt;
            r_ovf         <= r_ovf | w_ovf_set;
            r_unf         <= r_unf | w_unf_set;
        end
    end

`ifdef SIMT_DIV_STATS_EN
    logic          w_div;
    logic [DW-1:0] w_depth_nxt;
    logic [15:0]   r_div_count;
    logic [DW-1:0] r_max_depth;

    assign w_div = w_in_update && (r_mask != '0) && !decoded_ret && !decoded_sync &&
                   !decoded_ssy && !decoded_jump && decoded_pc_mux &&
                   (w_taken != '0) && (w_taken != r_mask);
    assign w_depth_nxt = stack_depth + DW'(w_push) - DW'(w_pop);
    assign div_count   = r_div_count;
    assign max_depth   = r_max_depth;

    // Saturating divergence counter and stack high-water mark.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_count <= 16'd0;
            r_max_depth <= '0;
        end else if (start) begin
            r_div_count <= 16'd0;
            r_max_depth <= '0;
        end else begin
            if (w_div && (r_div_count != 16'hFFFF)) begin
                r_div_count <= r_div_count + 16'd1;
            end else begin
                r_div_count <= r_div_count;
            end
            if (w_depth_nxt > r_max_depth) begin
                r_max_depth <= w_depth_nxt;
            end else begin
                r_max_depth <= r_max_depth;
            end
        end
    end
`else
    assign div_count = 16'd0;
    assign max_depth = '0;
`endif

endmodule
